// File: rtl/reqack_tph2rdyval.sv
// rtl/reqack_tph2rdyval.sv - two-phase req/ack receiver feeding a one-word ready/valid holding register
module reqack_tph2rdyval #(
    parameter int DWIDTH      = 1,
    parameter bit INCLUDE_CDC = 1'b0,
    parameter int CDC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [DWIDTH-1:0] i_dat,
    output logic              ack,
    output logic              vld,
    input  logic              rdy,
    output logic [DWIDTH-1:0] o_dat
);

    logic              req_i;
    logic              pending;
    logic              capture;
    logic              ack_q, ack_d;
    logic              vld_q, vld_d;
    logic [DWIDTH-1:0] dat_q, dat_d;

    generate
        if (INCLUDE_CDC) begin : g_cdc
            if (CDC_STAGES < 2 || CDC_STAGES > 4) begin : g_bad_stages
                $error("reqack_tph2rdyval: CDC_STAGES must be in 2..4");
            end
            logic [CDC_STAGES-1:0] sync_q, sync_d;

            always_comb begin
                sync_d = {sync_q[CDC_STAGES-2:0], req};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign req_i = sync_q[CDC_STAGES-1];
        end else begin : g_no_cdc
            assign req_i = req;
        end
    endgenerate

    // A new word is taken whenever the holding register is empty or draining this cycle.
    assign pending = req_i ^ ack_q;
    assign capture = pending & (~vld_q | rdy);

    always_comb begin
        ack_d = ack_q;
        vld_d = vld_q;
        dat_d = dat_q;
        if (capture) begin
            dat_d = i_dat;
            vld_d = 1'b1;
            ack_d = ~ack_q;
        end else if (vld_q && rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            vld_q <= vld_d;
        end
    end

    // Data register needs no reset: it is only meaningful while vld is high.
    always_ff @(posedge clk) begin
        dat_q <= dat_d;
    end

    assign ack   = ack_q;
    assign vld   = vld_q;
    assign o_dat = dat_q;

endmodule

// File: doc/reqack_tph2rdyval.md
Name: reqack_tph2rdyval

Overview:
Receiving end of the two-phase (toggle) Request–Acknowledge handshake. Converts an incoming req/ack two-phase transfer into an output Ready–Valid stream with a one-word output holding register. It pairs with the two-phase transmitter on the far side of a link, which may be in another clock domain. Optional CDC synchronizer stages on the incoming req line; i_dat is never synchronized, because the protocol keeps it stable while a request is pending.

Parameters:
DWIDTH, 1, data path bit width (>=1).
INCLUDE_CDC, 1'b0, when set, req passes through CDC_STAGES synchronizer flops before use.
CDC_STAGES, 2, synchronizer depth, legal 2..4, used only when INCLUDE_CDC=1; out-of-range value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active high
req  input  1  two-phase request from transmitter; a toggle means a new word is on i_dat
i_dat  input  DWIDTH  request data, stable from req toggle until matching ack toggle
ack  output  1  two-phase acknowledge; toggles once per captured word
vld  output  1  output Valid
rdy  input  1  output Ready from downstream
o_dat  output  DWIDTH  output data, valid while vld=1

Behaviour:
- req_i = req (INCLUDE_CDC=0), or the output of a CDC_STAGES-deep shift chain clocked by clk (INCLUDE_CDC=1). All sync flops reset to 0.
- pending = req_i ^ ack. A word is waiting when req_i and ack differ.
- capture = pending & (~vld | rdy).
- On capture at a clk edge:
  - o_dat <= i_dat
  - vld <= 1
  - ack <= ~ack
- Else if vld & rdy: vld <= 0.
- Ack is "early": it toggles when the word enters the holding register, not when it leaves downstream.
- Simultaneous drain and pending: the new word is captured on the same edge. vld stays 1, o_dat updates and ack toggles, so there is no bubble.
- Valid rules:
  - Once vld=1, vld and o_dat hold until the cycle with rdy=1.
  - vld never depends combinationally on rdy.
  - rdy may toggle freely while vld=0.
- Latency, INCLUDE_CDC=0: req toggles before edge n, then vld=1 and ack toggled after edge n (1 cycle).
- Latency, INCLUDE_CDC=1: CDC_STAGES+1 cycles.
- Throughput: a same-clock, no-CDC pairing with a combinational-ready transmitter gives 1 word per 2 cycles. With CDC it is bounded by the round-trip synchronizer latency.
- Full condition: vld=1 & rdy=0 & pending. The word stays pending, ack is not toggled, and the transmitter stalls. No data loss and no overwrite of o_dat.
- Empty condition: vld=0 & ~pending. Outputs are idle and ack is stable.
- Wrap-around: req and ack are 1-bit toggles, so only parity matters. Any number of transfers is legal.
- Reset (sync, priority over everything): ack=0, vld=0, sync chain=0.
- o_dat has no reset. It is undefined until the first capture, and benches must not check it while vld=0.
- Reset mid-operation: any held or pending word is dropped. The transmitter must be reset in the same window so its req returns to 0; otherwise a stale parity difference yields one spurious transfer after reset release.
- i_dat is sampled only on capture. With CDC, sampling happens at least CDC_STAGES cycles after req changes, so i_dat has settled.

Test Plan:
1. Single word, no CDC: rdy=1, toggle req 0->1 with i_dat=0xA5 (DWIDTH=8) → next edge vld=1, o_dat=0xA5, ack=1; next edge vld=0; no further ack change.
2. Backpressure: rdy=0, send 0x11 then toggle req again with 0x22 → vld=1, o_dat=0x11, ack=1 and held for 10 cycles (second word pending, ack not toggled). Raise rdy for 1 cycle → o_dat=0x22 on the same edge, vld stays 1, ack=0.
3. Streaming against paired transmitter, same clock, rdy=1: send 0..255 → output sequence 0..255 in order, no duplicates or drops, one word per 2 cycles.
4. CDC, INCLUDE_CDC=1 and CDC_STAGES=3: req toggle → vld asserts exactly 4 cycles later; random rdy and a random-phase transmitter clock → in-order lossless 1000-word stream.
5. Reset mid-operation: assert rst while vld=1 and a word is pending, with req also forced to 0 → next edge vld=0, ack=0; after release no vld until a new req toggle.
6. Random rdy with 30% duty, 500 words → vld/o_dat stable whenever vld&~rdy; ack toggle count equals the number of transfers accepted downstream plus held words.
